// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed little-endian byte stream into 32-bit imem writes
// and holds the core in reset until the whole image has been written.
module imem_loader #(
  parameter int DEPTH_WORDS = 24576,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_hold
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;
  state_t            r_state, w_next;
  logic [1:0]        r_bidx;
  logic [23:0]       r_asm;
  logic [ADDR_W:0]   r_n, r_words, w_words_inc;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data, w_word;
  logic              w_ready, w_accept, w_last, w_restart, w_final;
  always_comb begin
    w_ready     = (r_state == S_HDR) || (r_state == S_DATA);
    w_accept    = in_valid & w_ready;
    w_last      = w_accept & (r_bidx == 2'd3);
    w_word      = {in_data, r_asm};
    w_words_inc = r_words + 1'b1;
    w_restart   = start & ~w_ready;
    w_final     = w_last & (r_state == S_DATA) & (w_words_inc == r_n);
    w_next      = r_state;
    case (r_state)
      S_HDR:   if (w_last) w_next = (w_word == 32'd0) ? S_DONE :
                                    (w_word > 32'(DEPTH_WORDS)) ? S_ERR : S_DATA;
      S_DATA:  if (w_final) w_next = S_DONE;
      default: if (start) w_next = S_HDR;
    endcase
  end
  // Earlier bytes shift down so the 4th byte completes the word combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bidx    <= '0;
      r_asm     <= '0;
      r_n       <= '0;
      r_words   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_last & (r_state == S_DATA);
      if (w_restart) begin
        r_bidx  <= '0;
        r_words <= '0;
      end else if (w_accept) begin
        r_bidx <= r_bidx + 2'd1;
        r_asm  <= {in_data, r_asm[23:8]};
        if (w_last && r_state == S_HDR) r_n <= w_word[ADDR_W:0];
        if (w_last && r_state == S_DATA) begin
          r_wr_addr <= r_words[ADDR_W-1:0];
          r_wr_data <= w_word;
          r_words   <= w_words_inc;
        end
      end
    end
  end
  assign in_ready     = w_ready;
  assign busy         = w_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign done         = r_state == S_DONE;
  assign error        = r_state == S_ERR;
  assign cpu_hold     = r_state != S_DONE;
  assign words_loaded = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader using a reduced, non-power-of-two depth.
module tb_imem_loader;
  localparam int DW = 96;
  localparam int AW = 7;
  localparam logic [AW:0] DWL = DW;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, wr_en, busy, done, error, cpu_hold;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic [AW:0] words_loaded;
  int errs = 0, checks = 0;
  logic [AW+31:0] q[$];
  logic [AW+31:0] exp_w;

  imem_loader #(.DEPTH_WORDS(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .error(error), .words_loaded(words_loaded), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write addr=%0d data=%h (none expected)", wr_addr, wr_data);
      end else begin
        exp_w = q.pop_front();
        if ({wr_addr, wr_data} !== exp_w || words_loaded !== {1'b0, wr_addr} + 1'b1) begin
          errs++;
          $display("FAIL write got addr=%0d data=%h wl=%0d exp addr=%0d data=%h wl=%0d",
                   wr_addr, wr_data, words_loaded, exp_w[AW+31:32], exp_w[31:0], exp_w[AW+31:32] + 1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int duty);
    int n = 0;
    bit acc = 0;
    while (!acc) begin
      in_data  = b;
      in_valid = ($urandom_range(0, 99) < duty);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        checks++; errs++;
        $display("FAIL send_byte timeout byte=%h in_ready=%b exp accepted", b, in_ready);
        acc = 1;
      end
    end
    in_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int duty);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], duty);
  endtask

  task automatic push_send(input int addr, input logic [31:0] w, input int duty);
    q.push_back({AW'(addr), w});
    send_word(w, duty);
  endtask

  task automatic pulse_start;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    checks++; if (cpu_hold !== 1'b1) begin errs++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if ({done, error, wr_en, busy} !== 4'b0) begin errs++; $display("FAIL rst_flags got=%b exp=0000", {done, error, wr_en, busy}); end
    checks++; if (words_loaded !== '0 || wr_addr !== '0 || wr_data !== '0) begin errs++; $display("FAIL rst_regs got wl=%0d a=%0d d=%h exp 0", words_loaded, wr_addr, wr_data); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    pulse_start;
    checks++; if (busy !== 1'b1 || cpu_hold !== 1'b1) begin errs++; $display("FAIL t2_start got busy=%b hold=%b exp 1 1", busy, cpu_hold); end
    send_word(32'd2, 100);
    push_send(0, 32'h13, 100);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 0) begin errs++; $display("FAIL t2_wr0_timing got en=%b a=%0d exp 1 0", wr_en, wr_addr); end
    push_send(1, 32'h6F, 100);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 1) begin errs++; $display("FAIL t2_wr1_timing got en=%b a=%0d exp 1 1", wr_en, wr_addr); end
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL t2_done got done=%b hold=%b rdy=%b exp 1 0 0", done, cpu_hold, in_ready); end
    @(posedge clk); #1;
    checks++; if (words_loaded !== 2 || wr_en !== 1'b0) begin errs++; $display("FAIL t2_count got wl=%0d en=%b exp 2 0", words_loaded, wr_en); end
    checks++; if (q.size() != 0) begin errs++; $display("FAIL t2_drain got=%0d pending exp=0", q.size()); end
  endtask

  task automatic test_throttled;
    pulse_start;
    send_word(32'd2, 30);
    push_send(0, 32'h13, 30);
    push_send(1, 32'h6F, 30);
    repeat (3) @(posedge clk); #1;
    checks++; if (done !== 1'b1 || words_loaded !== 2) begin errs++; $display("FAIL t3_done got done=%b wl=%0d exp 1 2", done, words_loaded); end
    checks++; if (q.size() != 0) begin errs++; $display("FAIL t3_drain got=%0d pending exp=0", q.size()); end
  endtask

  task automatic test_header_edges;
    pulse_start;
    send_word(32'd0, 100);
    checks++; if (done !== 1'b1 || words_loaded !== 0 || in_ready !== 1'b0) begin errs++; $display("FAIL t4_zero got done=%b wl=%0d rdy=%b exp 1 0 0", done, words_loaded, in_ready); end
    repeat (4) @(posedge clk); #1;
    pulse_start;
    send_word(32'(DW), 100);
    for (int i = 0; i < DW; i++) push_send(i, $urandom, 100);
    checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(DW - 1) || done !== 1'b1) begin errs++; $display("FAIL t4_full got en=%b a=%0d done=%b exp 1 %0d 1", wr_en, wr_addr, done, DW - 1); end
    @(posedge clk); #1;
    checks++; if (words_loaded !== DWL || q.size() != 0) begin errs++; $display("FAIL t4_full_count got wl=%0d pend=%0d exp %0d 0", words_loaded, q.size(), DW); end
    pulse_start;
    send_word(32'(DW + 1), 100);
    checks++; if (error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL t4_over got err=%b rdy=%b hold=%b done=%b exp 1 0 1 0", error, in_ready, cpu_hold, done); end
    in_valid = 1; in_data = 8'hA5;
    repeat (8) @(posedge clk); #1;
    in_valid = 0;
    checks++; if (error !== 1'b1 || words_loaded !== 0) begin errs++; $display("FAIL t4_over_idle got err=%b wl=%0d exp 1 0", error, words_loaded); end
    pulse_start;
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL t4_err_restart got err=%b busy=%b exp 0 1", error, busy); end
    send_word(32'd0, 100);
  endtask

  task automatic test_reset_mid;
    pulse_start;
    send_word(32'd8, 100);
    for (int i = 0; i < 5; i++) push_send(i, $urandom, 100);
    send_byte(8'h11, 100);
    send_byte(8'h22, 100);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 0) begin errs++; $display("FAIL t5_reset got rdy=%b busy=%b hold=%b wl=%0d exp 0 0 1 0", in_ready, busy, cpu_hold, words_loaded); end
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk); #1;
    checks++; if (q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL t5_idle got pend=%0d busy=%b done=%b exp 0 0 0", q.size(), busy, done); end
    pulse_start;
    send_word(32'd3, 100);
    for (int i = 0; i < 3; i++) push_send(i, $urandom, 60);
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || words_loaded !== 3 || q.size() != 0) begin errs++; $display("FAIL t5_reload got done=%b wl=%0d pend=%0d exp 1 3 0", done, words_loaded, q.size()); end
  endtask

  task automatic test_restart;
    pulse_start;
    send_word(32'd4, 100);
    push_send(0, 32'hDEAD_0000, 100);
    pulse_start;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || words_loaded !== 1) begin errs++; $display("FAIL t6_busy_start got busy=%b done=%b wl=%0d exp 1 0 1", busy, done, words_loaded); end
    for (int i = 1; i < 4; i++) push_send(i, 32'hDEAD_0000 + i, 100);
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || words_loaded !== 4) begin errs++; $display("FAIL t6_first got done=%b wl=%0d exp 1 4", done, words_loaded); end
    start = 1; in_valid = 1; in_data = 8'h02;
    @(posedge clk); #1;
    start = 0; in_valid = 0;
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1 || words_loaded !== 0) begin errs++; $display("FAIL t6_restart got done=%b hold=%b busy=%b wl=%0d exp 0 1 1 0", done, cpu_hold, busy, words_loaded); end
    send_word(32'd2, 100);
    push_send(0, 32'hBEEF_0001, 100);
    push_send(1, 32'hBEEF_0002, 100);
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || words_loaded !== 2 || q.size() != 0) begin errs++; $display("FAIL t6_second got done=%b wl=%0d pend=%0d exp 1 2 0", done, words_loaded, q.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_throttled;
    test_header_edges;
    test_reset_mid;
    test_restart;
    repeat (3) @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
